// File: rtl/ddr_word_tx.sv
// Dual-edge serial transmitter: accepts parallel words over valid/ready and sends
// each one as a SYNC pair followed by WIDTH/2 bit pairs, one bit per clk phase.
module ddr_word_tx #(
    parameter int WIDTH   = 16,
    parameter int MIN_GAP = 0
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             dout,
    output logic             dout_frame,
    output logic             busy,
    output logic [1:0]       fsm_state
);

    // Handshake: a word transfers on the posedge where din_valid && din_ready;
    // din_ready depends only on registered state, never on din_valid.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam int             CW        = $clog2(WIDTH / 2 + 1);
    localparam logic [CW-1:0]  DATA_LAST = CW'(WIDTH / 2 - 1);
    localparam logic [3:0]     GAP_LAST  = 4'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);

    state_t           state;
    logic [WIDTH-1:0] hold;
    logic             hold_full;
    logic [WIDTH-1:0] shift;
    logic [CW-1:0]    data_cnt;
    logic [3:0]       gap_cnt;
    logic             frame;
    logic             q1;
    logic             q2;
    logic             o_bit;

    logic accept;
    logic data_done;
    logic gap_done;
    logic start_sync;

    assign accept    = din_valid && !hold_full;
    assign data_done = (state == DATA) && (data_cnt == '0);
    assign gap_done  = (state == GAP) && (gap_cnt == '0);
    assign start_sync = hold_full &&
                        ((state == IDLE) || gap_done || (data_done && (MIN_GAP == 0)));

    // q1 carries the even bit (encoded against q2) so dout = q1^q2 shows it while clk is high.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state     <= IDLE;
            hold      <= '0;
            hold_full <= 1'b0;
            shift     <= '0;
            data_cnt  <= '0;
            gap_cnt   <= '0;
            frame     <= 1'b0;
            q1        <= 1'b0;
            o_bit     <= 1'b0;
        end else begin
            if (start_sync) begin
                hold_full <= 1'b0;
            end else if (accept) begin
                hold      <= din;
                hold_full <= 1'b1;
            end

            if (start_sync) begin
                state <= SYNC;
                shift <= hold;
                frame <= 1'b1;
                q1    <= ~q2;
                o_bit <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        frame <= 1'b0;
                        q1    <= q2;
                        o_bit <= 1'b0;
                    end
                    SYNC: begin
                        state    <= DATA;
                        data_cnt <= DATA_LAST;
                        frame    <= 1'b1;
                        q1       <= shift[WIDTH-1] ^ q2;
                        o_bit    <= shift[WIDTH-2];
                        shift    <= shift << 2;
                    end
                    DATA: begin
                        if (data_cnt != '0) begin
                            data_cnt <= data_cnt - CW'(1);
                            frame    <= 1'b1;
                            q1       <= shift[WIDTH-1] ^ q2;
                            o_bit    <= shift[WIDTH-2];
                            shift    <= shift << 2;
                        end else begin
                            state   <= (MIN_GAP > 0) ? GAP : IDLE;
                            gap_cnt <= GAP_LAST;
                            frame   <= 1'b0;
                            q1      <= q2;
                            o_bit   <= 1'b0;
                        end
                    end
                    GAP: begin
                        if (gap_cnt != '0) begin
                            gap_cnt <= gap_cnt - 4'(1);
                        end else begin
                            state <= IDLE;
                        end
                        frame <= 1'b0;
                        q1    <= q2;
                        o_bit <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        frame <= 1'b0;
                        q1    <= q2;
                        o_bit <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Odd bit lands at the negedge; only one of q1/q2 toggles per edge, so dout never glitches.
    always_ff @(negedge clk or negedge rstb) begin
        if (!rstb) begin
            q2 <= 1'b0;
        end else begin
            q2 <= o_bit ^ q1;
        end
    end

    assign dout       = q1 ^ q2;
    assign dout_frame = frame;
    assign din_ready  = !hold_full;
    assign busy       = (state != IDLE) || hold_full;
    assign fsm_state  = state;

endmodule

// File: tb/tb_ddr_word_tx.sv
// Bench for ddr_word_tx: directed frame timing, back-to-back, gap, reset and backpressure
// tests plus a decoding monitor that checks every frame against an expected-word queue.
module tb_ddr_word_tx;

    logic        clk;
    logic        rstb;
    logic [15:0] din0, din3;
    logic        valid0, valid3;
    logic        ready0, ready3;
    logic        dout0, dout3;
    logic        frame0, frame3;
    logic        busy0, busy3;
    logic [1:0]  st0, st3;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_q0[$];
    logic [15:0] exp_q3[$];
    int          gap_q0[$];
    int          gap_q3[$];

    int          mon_pos[2];
    logic [15:0] mon_word[2];
    int          mon_gap[2];
    bit          mon_en;

    ddr_word_tx #(.WIDTH(16), .MIN_GAP(0)) dut0 (
        .clk(clk), .rstb(rstb), .din(din0), .din_valid(valid0), .din_ready(ready0),
        .dout(dout0), .dout_frame(frame0), .busy(busy0), .fsm_state(st0)
    );

    ddr_word_tx #(.WIDTH(16), .MIN_GAP(3)) dut3 (
        .clk(clk), .rstb(rstb), .din(din3), .din_valid(valid3), .din_ready(ready3),
        .dout(dout3), .dout_frame(frame3), .busy(busy3), .fsm_state(st3)
    );

    // clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // monitor: decodes frames on both lines and scores them against the expected queues
    task automatic mon_step(input int id, input logic e, input logic o, input logic f);
        logic [15:0] w;
        if (f) begin
            if (mon_pos[id] == 0) begin
                check(id == 0 ? "m0_sync" : "m3_sync", {30'd0, e, o}, 32'd2);
                if (id == 0) gap_q0.push_back(mon_gap[id]);
                else gap_q3.push_back(mon_gap[id]);
                mon_gap[id]  = 0;
                mon_pos[id]  = 1;
                mon_word[id] = '0;
            end else begin
                mon_word[id] = {mon_word[id][13:0], e, o};
                mon_pos[id]++;
                if (mon_pos[id] == 9) begin
                    mon_pos[id] = 0;
                    if (id == 0) begin
                        if (exp_q0.size() == 0) check("m0_queue", exp_q0.size(), 1);
                        else begin
                            w = exp_q0.pop_front();
                            check("m0_word", mon_word[id], w);
                        end
                    end else begin
                        if (exp_q3.size() == 0) check("m3_queue", exp_q3.size(), 1);
                        else begin
                            w = exp_q3.pop_front();
                            check("m3_word", mon_word[id], w);
                        end
                    end
                end
            end
        end else begin
            check(id == 0 ? "m0_idle_pair" : "m3_idle_pair", {30'd0, e, o}, 32'd0);
            if (mon_pos[id] != 0) begin
                check("frame_len", mon_pos[id], 9);
                mon_pos[id] = 0;
            end
            mon_gap[id]++;
        end
    endtask

    logic e0_s, f0_s, e3_s, f3_s;

    always begin
        @(posedge clk);
        #1;
        e0_s = dout0;
        f0_s = frame0;
        e3_s = dout3;
        f3_s = frame3;
        @(negedge clk);
        #1;
        if (mon_en) begin
            mon_step(0, e0_s, dout0, f0_s);
            mon_step(1, e3_s, dout3, f3_s);
        end
    end

    // driver tasks
    task automatic drive(input int id, input logic v, input logic [15:0] d);
        if (id == 0) begin
            valid0 = v;
            din0   = d;
        end else begin
            valid3 = v;
            din3   = d;
        end
    endtask

    task automatic send_word(input int id, input logic [15:0] w, input bit churn);
        logic        rdy;
        logic [15:0] cur;
        int          waited;
        waited = 0;
        cur    = w;
        @(negedge clk);
        drive(id, 1'b1, cur);
        forever begin
            rdy = (id == 0) ? ready0 : ready3;
            @(posedge clk);
            if (rdy) break;
            waited++;
            if (waited > 200) begin
                check("accept_timeout", waited, 0);
                return;
            end
            @(negedge clk);
            if (churn) begin
                cur = 16'($urandom);
                drive(id, 1'b1, cur);
            end
        end
        if (id == 0) exp_q0.push_back(cur);
        else exp_q3.push_back(cur);
        #1;
        check("ready_after_accept", (id == 0) ? ready0 : ready3, 0);
    endtask

    task automatic drop_valid(input int id);
        @(negedge clk);
        drive(id, 1'b0, 16'h0000);
    endtask

    task automatic wait_done(input int id);
        int n;
        for (n = 0; n < 300; n++) begin
            @(negedge clk);
            #2;
            if (id == 0 && exp_q0.size() == 0 && !busy0) break;
            if (id == 1 && exp_q3.size() == 0 && !busy3) break;
        end
        if (n >= 300) check("drain_timeout", n, 0);
    endtask

    task automatic read_pair(output logic e, output logic o, output logic f);
        @(posedge clk);
        #1;
        e = dout0;
        f = frame0;
        @(negedge clk);
        #1;
        o = dout0;
    endtask

    // stimulus
    initial begin
        logic        e, o, f;
        logic [31:0] stream;
        logic        acc;
        bit          busy_all;
        int          n;

        mon_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            mon_pos[i]  = 0;
            mon_word[i] = '0;
            mon_gap[i]  = 0;
        end
        rstb = 1'b1;
        drive(0, 1'b0, 16'h0000);
        drive(1, 1'b0, 16'h0000);
        #2 rstb = 1'b0;
        #1;
        check("rst_dout", dout0, 0);
        check("rst_frame", frame0, 0);
        check("rst_busy", busy0, 0);
        check("rst_ready", ready0, 1);
        check("rst_state", st0, 0);
        check("rst_dout3", dout3, 0);
        repeat (3) @(negedge clk);
        rstb = 1'b1;
        repeat (2) @(negedge clk);

        // single word A5C3: SYNC on the cycle after accept, then 8 data pairs, then idle
        send_word(0, 16'hA5C3, 1'b0);
        check("t1_busy", busy0, 1);
        @(negedge clk);
        drive(0, 1'b0, 16'h0000);
        stream = '0;
        for (int c = 0; c < 9; c++) begin
            read_pair(e, o, f);
            stream = {stream[29:0], e, o};
            check("t1_frame", f, 1);
        end
        check("t1_stream", stream, {14'd0, 2'b10, 16'hA5C3});
        read_pair(e, o, f);
        check("t1_tail_frame", f, 0);
        check("t1_tail_pair", {e, o}, 0);
        check("t1_tail_busy", busy0, 0);
        check("t1_tail_state", st0, 0);
        wait_done(0);

        // back-to-back with continuous valid: contiguous frames
        gap_q0.delete();
        send_word(0, 16'hFFFF, 1'b0);
        send_word(0, 16'h0001, 1'b0);
        send_word(0, 16'h8000, 1'b0);
        drop_valid(0);
        wait_done(0);
        check("b2b_frames", gap_q0.size(), 3);
        if (gap_q0.size() == 3) begin
            check("b2b_gap1", gap_q0[1], 0);
            check("b2b_gap2", gap_q0[2], 0);
        end

        // MIN_GAP=3: two queued words, exactly 3 idle pairs between frames, busy held
        gap_q3.delete();
        send_word(1, 16'h1234, 1'b0);
        send_word(1, 16'hBEEF, 1'b0);
        drop_valid(1);
        busy_all = 1'b1;
        for (n = 0; n < 100; n++) begin
            @(posedge clk);
            #1;
            if (exp_q3.size() == 0) break;
            busy_all &= busy3;
        end
        check("gap_busy", busy_all, 1);
        wait_done(1);
        check("gap_frames", gap_q3.size(), 2);
        if (gap_q3.size() == 2) check("gap_len", gap_q3[1], 3);

        // reset during DATA cycle 4 with a second word held
        send_word(0, 16'h5A5A, 1'b0);
        send_word(0, 16'hC001, 1'b0);
        drop_valid(0);
        repeat (3) @(posedge clk);
        #2;
        mon_en = 1'b0;
        rstb   = 1'b0;
        #1;
        check("mid_rst_dout", dout0, 0);
        check("mid_rst_frame", frame0, 0);
        check("mid_rst_ready", ready0, 1);
        check("mid_rst_busy", busy0, 0);
        exp_q0.delete();
        mon_pos[0] = 0;
        repeat (2) @(negedge clk);
        rstb = 1'b1;
        acc  = 1'b0;
        for (int c = 0; c < 12; c++) begin
            read_pair(e, o, f);
            acc = acc | e | o | f;
        end
        check("mid_rst_residual", acc, 0);
        check("mid_rst_state", st0, 0);
        mon_en = 1'b1;

        // backpressure: din churns every cycle while not ready
        send_word(0, 16'h0F0F, 1'b1);
        send_word(0, 16'h3C3C, 1'b1);
        send_word(0, 16'h7E7E, 1'b1);
        drop_valid(0);
        wait_done(0);

        // loopback: random words with random idle spacing
        for (int i = 0; i < 1000; i++) begin
            send_word(0, 16'($urandom), 1'b0);
            if ($urandom_range(0, 3) == 0) begin
                drop_valid(0);
                repeat ($urandom_range(0, 12)) @(negedge clk);
            end
        end
        drop_valid(0);
        wait_done(0);
        check("final_q0", exp_q0.size(), 0);
        check("final_q3", exp_q3.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
